// File: rtl/bin_bcd_display_fmt_pkg.sv
// Shared definitions for the binary-to-BCD display formatting stage.
//   NUM_DIGITS / BCD_W : display geometry (8 digits of 4-bit BCD)
//   MAX_DEC            : largest value the 8 digits can show
//   fmt_state_t        : converter FSM states
//   HEX_RST/BLANK_RST  : values the committed outputs take in reset
package bin_bcd_display_fmt_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = 4;
  localparam int HEX_W      = NUM_DIGITS * BCD_W;

  localparam int unsigned MAX_DEC = 32'd99_999_999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } fmt_state_t;

  // Reset display: a single "0" with the upper seven digits blanked.
  localparam logic [HEX_W-1:0]      HEX_RST   = '0;
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = 8'hFE;

endpackage

// File: rtl/bin_bcd_display_fmt_scan_ce_gen.sv
// Free-running digit-scan strobe generator.
//   CLK     : system clock, rising edge
//   RST_N   : asynchronous active-low reset
//   SCAN_CE : one-cycle strobe, once every CLK_DIV cycles
// The strobe is registered so it is glitch-free and low during reset. The
// counter runs 0..CLK_DIV-1; the strobe is asserted in the cycle following
// the edge at which the counter wraps, so the first strobe appears after the
// CLK_DIV-th edge following reset release (every cycle when CLK_DIV=1).
module scan_ce_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic CLK,
  input  logic RST_N,
  output logic SCAN_CE
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt_reg;
  logic             scan_ce_reg;
  logic             wrap;

  assign wrap = (div_cnt_reg == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_reg <= '0;
      scan_ce_reg <= 1'b0;
    end else begin
      scan_ce_reg <= wrap;
      div_cnt_reg <= wrap ? '0 : div_cnt_reg + CNT_W'(1);
    end
  end

  assign SCAN_CE = scan_ce_reg;

endmodule

// File: rtl/bin_bcd_display_fmt.sv
// Binary to 8-digit BCD formatter feeding the multiplexed 7-segment driver.
//   CLK, RST_N  : clock (rising edge), asynchronous active-low reset
//   START       : conversion request, honoured only while BUSY=0
//   BIN_IN      : unsigned value, saturated to 99_999_999
//   DP_IN       : decimal-point mask, bit i = digit i
//   LZB_EN      : leading-zero blanking enable
//   BUSY, DONE  : conversion in progress / one-cycle completion pulse
//   OVF         : last committed value was saturated
//   HEX_OUT     : packed BCD, [3:0] = least significant digit
//   BLANK_OUT   : bit i = 1 suppresses digit i
//   DP_OUT      : committed decimal-point mask
//   SCAN_CE     : digit-scan strobe for the driver
// Conversion is iterative double-dabble, one bit per clock, into a working
// shift register; the display outputs are a separate register bank loaded
// only in COMMIT, so the driver never sees a half-converted value.
import bin_bcd_display_fmt_pkg::*;

module bin_bcd_display_fmt #(
  parameter int BIN_W   = 27,
  parameter int CLK_DIV = 50000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [BIN_W-1:0] BIN_IN,
  input  logic [7:0]       DP_IN,
  input  logic             LZB_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic [31:0]      HEX_OUT,
  output logic [7:0]       BLANK_OUT,
  output logic [7:0]       DP_OUT,
  output logic             SCAN_CE
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SR_W  = HEX_W + BIN_W;

  fmt_state_t state_reg;
  fmt_state_t state_next;

  logic [CNT_W-1:0]      iter_cnt_reg;
  logic [SR_W-1:0]       sr_reg;        // {BCD digits, remaining binary bits}
  logic [7:0]            dp_cap_reg;
  logic                  lzb_cap_reg;
  logic                  ovf_cap_reg;

  logic [HEX_W-1:0]      hex_out_reg;
  logic [NUM_DIGITS-1:0] blank_out_reg;
  logic [7:0]            dp_out_reg;
  logic                  ovf_out_reg;
  logic                  done_reg;

  // Saturation: compare in a widened domain so any BIN_W works.
  logic [BIN_W+31:0]     bin_ext;
  logic                  bin_ovf;
  logic [BIN_W-1:0]      bin_sat;

  assign bin_ext = {32'd0, BIN_IN};
  assign bin_ovf = (bin_ext > (BIN_W + 32)'(MAX_DEC));
  assign bin_sat = bin_ovf ? BIN_W'(MAX_DEC) : BIN_IN;

  // Double-dabble step: correct every nibble >= 5 by +3, then shift left.
  // Nibbles never exceed 9 here, so the 4-bit add cannot carry out.
  logic [HEX_W-1:0] bcd_adj;
  logic [SR_W-1:0]  sr_shift;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      logic [BCD_W-1:0] nib;
      assign nib = sr_reg[BIN_W + gi*BCD_W +: BCD_W];
      assign bcd_adj[gi*BCD_W +: BCD_W] = (nib >= BCD_W'(5)) ? nib + BCD_W'(3) : nib;
    end
  endgenerate

  assign sr_shift = {bcd_adj[HEX_W-2:0], sr_reg[BIN_W-1:0], 1'b0};

  // Leading-zero blanking: upper_zero[i] = digits i..7 are all zero.
  // Digit 0 is never blanked so a value of 0 still shows "0".
  logic [NUM_DIGITS:1]   upper_zero;
  logic [NUM_DIGITS-1:0] blank_calc;

  assign upper_zero[NUM_DIGITS] = 1'b1;
  assign blank_calc[0]          = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
      assign upper_zero[gi] = (sr_reg[BIN_W + gi*BCD_W +: BCD_W] == '0) & upper_zero[gi+1];
      assign blank_calc[gi] = lzb_cap_reg & upper_zero[gi];
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state. The counter is loaded with BIN_W and the last
  // iteration runs while it reads 1.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (START) state_next = SHIFT;
      SHIFT:   if (iter_cnt_reg == CNT_W'(1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and committed output bank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      iter_cnt_reg  <= '0;
      sr_reg        <= '0;
      dp_cap_reg    <= '0;
      lzb_cap_reg   <= 1'b0;
      ovf_cap_reg   <= 1'b0;
      hex_out_reg   <= HEX_RST;
      blank_out_reg <= BLANK_RST;
      dp_out_reg    <= '0;
      ovf_out_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            sr_reg       <= {{HEX_W{1'b0}}, bin_sat};
            iter_cnt_reg <= CNT_W'(BIN_W);
            dp_cap_reg   <= DP_IN;
            lzb_cap_reg  <= LZB_EN;
            ovf_cap_reg  <= bin_ovf;
          end
        end
        SHIFT: begin
          sr_reg       <= sr_shift;
          iter_cnt_reg <= iter_cnt_reg - CNT_W'(1);
        end
        COMMIT: begin
          hex_out_reg   <= sr_reg[SR_W-1:BIN_W];
          blank_out_reg <= blank_calc;
          dp_out_reg    <= dp_cap_reg;
          ovf_out_reg   <= ovf_cap_reg;
          done_reg      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY      = (state_reg != IDLE);
  assign DONE      = done_reg;
  assign OVF       = ovf_out_reg;
  assign HEX_OUT   = hex_out_reg;
  assign BLANK_OUT = blank_out_reg;
  assign DP_OUT    = dp_out_reg;

  scan_ce_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_scan_ce_gen (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .SCAN_CE (SCAN_CE)
  );

endmodule

// File: tb/tb_bin_bcd_display_fmt.sv
// Self-checking bench for bin_bcd_display_fmt: directed cases plus random
// values checked against a decimal-arithmetic reference model.
module tb_bin_bcd_display_fmt;

  localparam int unsigned MAX_V = 32'd99_999_999;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [26:0] BIN_IN;
  logic [7:0]  DP_IN;
  logic        LZB_EN;
  logic        BUSY, DONE, OVF, SCAN_CE;
  logic [31:0] HEX_OUT;
  logic [7:0]  BLANK_OUT, DP_OUT;

  // Second instance only for the CLK_DIV=1 strobe.
  logic        START1;
  logic [26:0] BIN_IN1;
  logic [7:0]  DP_IN1;
  logic        LZB_EN1;
  logic        BUSY1, DONE1, OVF1, SCAN_CE1;
  logic [31:0] HEX_OUT1;
  logic [7:0]  BLANK_OUT1, DP_OUT1;

  int checks = 0;
  int errors = 0;

  bin_bcd_display_fmt #(.BIN_W(27), .CLK_DIV(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BIN_IN(BIN_IN), .DP_IN(DP_IN),
    .LZB_EN(LZB_EN), .BUSY(BUSY), .DONE(DONE), .OVF(OVF), .HEX_OUT(HEX_OUT),
    .BLANK_OUT(BLANK_OUT), .DP_OUT(DP_OUT), .SCAN_CE(SCAN_CE)
  );

  bin_bcd_display_fmt #(.BIN_W(27), .CLK_DIV(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(START1), .BIN_IN(BIN_IN1), .DP_IN(DP_IN1),
    .LZB_EN(LZB_EN1), .BUSY(BUSY1), .DONE(DONE1), .OVF(OVF1), .HEX_OUT(HEX_OUT1),
    .BLANK_OUT(BLANK_OUT1), .DP_OUT(DP_OUT1), .SCAN_CE(SCAN_CE1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: plain decimal arithmetic on the saturated value.
  function automatic logic [31:0] ref_hex(input int unsigned v);
    int unsigned s;
    logic [31:0] h;
    s = (v > MAX_V) ? MAX_V : v;
    h = '0;
    for (int i = 0; i < 8; i++) begin
      h[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return h;
  endfunction

  function automatic logic [7:0] ref_blank(input int unsigned v, input logic lzb);
    int unsigned s;
    int n;
    logic [7:0] m;
    s = (v > MAX_V) ? MAX_V : v;
    n = 1;
    while (s >= 10) begin
      s = s / 10;
      n++;
    end
    m = 8'hFF;
    m = m << n;
    return lzb ? m : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_pulse(input int unsigned v, input logic [7:0] dp, input logic lzb);
    BIN_IN = 27'(v);
    DP_IN  = dp;
    LZB_EN = lzb;
    START  = 1'b1;
    tick();
    START  = 1'b0;
  endtask

  // Counts edges until DONE (bounded) and tracks HEX_OUT stability meanwhile.
  task automatic wait_done(output int cyc, output bit stable);
    logic [31:0] h0;
    h0 = HEX_OUT;
    cyc = 0;
    stable = 1'b1;
    while (DONE !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      if (DONE !== 1'b1 && HEX_OUT !== h0) stable = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input int unsigned v,
                              input logic [7:0] dp, input logic lzb);
    check({tag, ".hex"},   HEX_OUT,          ref_hex(v));
    check({tag, ".blank"}, 32'(BLANK_OUT),   32'(ref_blank(v, lzb)));
    check({tag, ".dp"},    32'(DP_OUT),      32'(dp));
    check({tag, ".ovf"},   32'(OVF),         32'(v > MAX_V));
    check({tag, ".busy0"}, 32'(BUSY),        32'd0);
  endtask

  task automatic run_conv(input string tag, input int unsigned v,
                          input logic [7:0] dp, input logic lzb);
    int cyc;
    bit stable;
    start_pulse(v, dp, lzb);
    check({tag, ".busy1"}, 32'(BUSY), 32'd1);
    wait_done(cyc, stable);
    check({tag, ".latency"}, 32'(cyc), 32'd28);
    check({tag, ".hold"}, 32'(stable), 32'd1);
    check_result(tag, v, dp, lzb);
    $display("conv %s bin=%0d dp=%02h lzb=%0d hex=%08h blank=%02h ovf=%0d",
             tag, v, dp, lzb, HEX_OUT, BLANK_OUT, OVF);
    tick();
    check({tag, ".done_pulse"}, 32'(DONE), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".busy"},  32'(BUSY),      32'd0);
    check({tag, ".done"},  32'(DONE),      32'd0);
    check({tag, ".ovf"},   32'(OVF),       32'd0);
    check({tag, ".hex"},   HEX_OUT,        32'h0);
    check({tag, ".blank"}, 32'(BLANK_OUT), 32'hFE);
    check({tag, ".dp"},    32'(DP_OUT),    32'h00);
  endtask

  initial begin
    int cyc;
    bit stable;
    int dones;
    int unsigned v;
    logic [7:0] dp;
    logic lzb;

    RST_N = 1'b0; START = 1'b0; BIN_IN = '0; DP_IN = '0; LZB_EN = 1'b0;
    START1 = 1'b0; BIN_IN1 = '0; DP_IN1 = '0; LZB_EN1 = 1'b0;

    // 1. Reset
    repeat (3) tick();
    check_reset_vals("reset");
    check("reset.scan_ce", 32'(SCAN_CE), 32'd0);
    check("reset.scan_ce1", 32'(SCAN_CE1), 32'd0);
    RST_N = 1'b1;

    // 6. SCAN_CE cadence with a START issued in the middle
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) begin
        BIN_IN = 27'd7; START = 1'b1;
      end else begin
        START = 1'b0;
      end
      tick();
      check($sformatf("scan_ce.k%0d", k), 32'(SCAN_CE), 32'((k % 4) == 0));
      check($sformatf("scan_ce1.k%0d", k), 32'(SCAN_CE1), 32'd1);
      $display("scan k=%0d scan_ce=%0d scan_ce1=%0d", k, SCAN_CE, SCAN_CE1);
    end
    START = 1'b0;
    repeat (30) tick();
    check("idle_after_scan", 32'(BUSY), 32'd0);

    // 2. Main example
    run_conv("ex12345678", 12_345_678, 8'h04, 1'b1);

    // 3. Blanking
    run_conv("b905", 905, 8'h00, 1'b1);
    run_conv("b0", 0, 8'h01, 1'b1);
    run_conv("b905nolzb", 905, 8'h10, 1'b0);

    // 4. Overflow and boundaries
    run_conv("ovf", 100_000_000, 8'h80, 1'b1);
    run_conv("after_ovf", 5, 8'h00, 1'b1);
    run_conv("max", 99_999_999, 8'h00, 1'b1);
    run_conv("ovf_top", 134_217_727, 8'h00, 1'b1);
    run_conv("ten_m", 10_000_000, 8'hFF, 1'b1);

    // Random values
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 99_999);
        default: v = $urandom_range(0, 120_000_000);
      endcase
      dp  = 8'($urandom);
      lzb = 1'($urandom_range(0, 1));
      run_conv($sformatf("rnd%0d", i), v, dp, lzb);
    end

    // 5a. Second START during conversion is ignored
    start_pulse(4321, 8'h22, 1'b1);
    repeat (9) tick();
    BIN_IN = 27'd777; DP_IN = 8'h55; LZB_EN = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(cyc, stable);
    check("restart.latency", 32'(cyc), 32'd18);
    check_result("restart", 4321, 8'h22, 1'b1);
    $display("restart hex=%08h blank=%02h dp=%02h", HEX_OUT, BLANK_OUT, DP_OUT);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DONE === 1'b1) dones++;
    end
    check("restart.extra_done", 32'(dones), 32'd0);

    // 5b. Reset during SHIFT
    start_pulse(8_765_432, 8'h0F, 1'b0);
    repeat (5) tick();
    RST_N = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) tick();
    RST_N = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DONE === 1'b1) dones++;
    end
    check("midreset.no_done", 32'(dones), 32'd0);
    check("midreset.hex_kept", HEX_OUT, 32'h0);
    $display("midreset dones=%0d hex=%08h", dones, HEX_OUT);

    // Converter still healthy after the aborted run
    run_conv("post_reset", 42, 8'h02, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
